// File: rtl/mem_arbiter.sv
// Two-requester RAM arbiter: instruction fetch vs. data load/store, with a
// starvation counter that forces a fetch grant after STARVE_MAX data grants.
module mem_arbiter #(
  parameter int WORD_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              ihit,
  output logic              dhit,
  output logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] dload,
  output logic              merr,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  state_t     next_state;
  logic [3:0] starve_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state <= next_state;
      if (ihit)
        starve_cnt <= '0;
      else if (dhit && iREN && starve_cnt < STARVE_LIM)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Completions are suppressed while RST is high so an aborted access never hits.
  always_comb begin
    next_state = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    ihit       = 1'b0;
    dhit       = 1'b0;
    merr       = 1'b0;
    iload      = '0;
    dload      = '0;
    case (state)
      IDLE: begin
        if (dREN || dWEN)
          next_state = (iREN && starve_cnt == STARVE_LIM) ? IGNT : DGNT;
        else if (iREN)
          next_state = IGNT;
      end
      IGNT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (!iREN) begin
          next_state = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          next_state = IDLE;
          ihit       = !RST;
          iload      = RST ? '0 : ramload;
        end else if (ramstate == RAM_ERROR) begin
          next_state = IDLE;
          merr       = !RST;
        end
      end
      DGNT: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!(dREN || dWEN)) begin
          next_state = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          next_state = IDLE;
          dhit       = !RST;
          dload      = RST ? '0 : ramload;
        end else if (ramstate == RAM_ERROR) begin
          next_state = IDLE;
          merr       = !RST;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios followed by random
// requester/RAM traffic checked against a transaction-level ownership model.
module tb_mem_arbiter;
  localparam int W    = 32;
  localparam int SMAX = 3;
  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [W-1:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [1:0]   ramstate = FREE;
  logic         ihit, dhit, merr, ramREN, ramWEN;
  logic [W-1:0] iload, dload, ramaddr, ramstore;

  mem_arbiter #(.WORD_W(W), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ihit(ihit), .dhit(dhit), .iload(iload),
    .dload(dload), .merr(merr), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int           cyc;
    int           kind;
    logic [W-1:0] data;
    logic [W-1:0] addr;
    logic         wen;
    logic [W-1:0] store;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0, failures = 0;
  bit  run = 1'b0;
  int  cyc = 0;
  int  owner = 0, starve = 0;
  int  exp_ren = 0, exp_wen = 0, dut_ren = 0, dut_wen = 0;
  int  dut_i_cnt = 0, dut_d_cnt = 0, dut_merr_cnt = 0;
  bit  last_ihit = 1'b0, last_dhit = 1'b0;

  task automatic check_output(input string name, input logic [W-1:0] actual,
                              input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, actual, expected);
    end
  endtask

  // Owner is who holds the RAM this cycle: 0 nobody, 1 fetch, 2 data.
  task automatic model_cycle();
    int  nxt;
    ev_t e;
    cyc++;
    nxt = owner;
    case (owner)
      1: begin
        exp_ren++;
        if (!iREN) nxt = 0;
        else if (ramstate == ACCESS) begin
          nxt = 0;
          if (!RST) begin
            e = '{cyc, 1, ramload, iaddr, 1'b0, '0};
            exp_q.push_back(e);
            starve = 0;
          end
        end else if (ramstate == ERROR) begin
          nxt = 0;
          if (!RST) begin
            e = '{cyc, 3, '0, iaddr, 1'b0, '0};
            exp_q.push_back(e);
          end
        end
      end
      2: begin
        exp_ren += int'(dREN);
        exp_wen += int'(dWEN);
        if (!dREN && !dWEN) nxt = 0;
        else if (ramstate == ACCESS) begin
          nxt = 0;
          if (!RST) begin
            e = '{cyc, 2, ramload, daddr, dWEN, dstore};
            exp_q.push_back(e);
            if (iREN && starve < SMAX) starve++;
          end
        end else if (ramstate == ERROR) begin
          nxt = 0;
          if (!RST) begin
            e = '{cyc, 3, '0, daddr, dWEN, dstore};
            exp_q.push_back(e);
          end
        end
      end
      default: begin
        if (dREN || dWEN) nxt = (iREN && starve == SMAX) ? 1 : 2;
        else if (iREN) nxt = 1;
      end
    endcase
    if (RST) begin
      nxt    = 0;
      starve = 0;
    end
    owner = nxt;
  endtask

  task automatic monitor_cycle();
    ev_t e;
    int  kind, n;
    dut_ren  += int'(ramREN);
    dut_wen  += int'(ramWEN);
    last_ihit = ihit;
    last_dhit = dhit;
    if (ihit) dut_i_cnt++;
    if (dhit) dut_d_cnt++;
    if (merr) dut_merr_cnt++;
    n = $countones({ihit, dhit, merr});
    if (n != 0) begin
      check_output("single_event", W'(n), W'(1));
      kind = ihit ? 1 : (dhit ? 2 : 3);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_event cycle=%0d actual_kind=%0d expected=none", cyc, kind);
      end else begin
        e = exp_q.pop_front();
        check_output("event_kind", W'(kind), W'(e.kind));
        check_output("event_addr", ramaddr, e.addr);
        check_output("event_wen", W'(ramWEN), W'(e.wen));
        check_output("event_store", ramstore, e.store);
        if (e.kind == 1) check_output("iload", iload, e.data);
        if (e.kind == 2) check_output("dload", dload, e.data);
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("[TB] FAIL missed_event cycle=%0d actual=none expected_kind=%0d", e.cyc, e.kind);
    end
    if (!ihit) check_output("iload_zero", iload, '0);
    if (!dhit) check_output("dload_zero", dload, '0);
  endtask

  always @(negedge CLK) begin
    if (run) begin
      #1;
      model_cycle();
    end
  end

  always @(negedge CLK) begin
    if (run) begin
      #2;
      monitor_cycle();
    end
  end

  task automatic apply_stimulus(input logic rst, input logic i_r, input logic d_r,
                                input logic d_w, input logic [W-1:0] ia,
                                input logic [W-1:0] da, input logic [W-1:0] ds,
                                input logic [W-1:0] rl, input logic [1:0] rs);
    @(negedge CLK);
    RST = rst; iREN = i_r; dREN = d_r; dWEN = d_w;
    iaddr = ia; daddr = da; dstore = ds; ramload = rl; ramstate = rs;
    #3;
  endtask

  task automatic random_cycle();
    logic         i_r, d_r, d_w, rst;
    logic [W-1:0] ia, da, ds;
    logic [1:0]   rs;
    int           r;
    i_r = iREN; d_r = dREN; d_w = dWEN; ia = iaddr; da = daddr; ds = dstore;
    if (last_ihit) i_r = 1'b0;
    else if (!i_r) begin
      if ($urandom_range(3) == 0) begin
        i_r = 1'b1;
        ia  = $urandom;
      end
    end else if ($urandom_range(31) == 0) i_r = 1'b0;
    if (last_dhit) begin
      d_r = 1'b0;
      d_w = 1'b0;
    end else if (!d_r && !d_w) begin
      if ($urandom_range(3) == 0) begin
        if ($urandom_range(1) == 1) d_r = 1'b1;
        else d_w = 1'b1;
        da = $urandom;
        ds = $urandom;
      end
    end else if ($urandom_range(31) == 0) begin
      d_r = 1'b0;
      d_w = 1'b0;
    end
    rst = ($urandom_range(63) == 0);
    r   = $urandom_range(7);
    rs  = (r < 2) ? FREE : (r < 5) ? BUSY : (r < 7) ? ACCESS : ERROR;
    apply_stimulus(rst, i_r, d_r, d_w, ia, da, ds, W'($urandom), rs);
  endtask

  initial begin
    int base_ren, start_i, start_d, start_m;
    logic i_r, d_w;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #2;
    check_output("reset_ramREN", W'(ramREN), '0);
    check_output("reset_ramWEN", W'(ramWEN), '0);
    check_output("reset_ihit", W'(ihit), '0);
    check_output("reset_dhit", W'(dhit), '0);
    check_output("reset_merr", W'(merr), '0);
    run = 1'b1;

    // Fetch with two BUSY cycles before ACCESS.
    base_ren = dut_ren;
    start_i  = dut_i_cnt;
    apply_stimulus(0, 1, 0, 0, W'(32'h40), '0, '0, '0, BUSY);
    apply_stimulus(0, 1, 0, 0, W'(32'h40), '0, '0, '0, BUSY);
    apply_stimulus(0, 1, 0, 0, W'(32'h40), '0, '0, '0, BUSY);
    apply_stimulus(0, 1, 0, 0, W'(32'h40), '0, '0, W'(32'h8C220004), ACCESS);
    apply_stimulus(0, 0, 0, 0, '0, '0, '0, '0, FREE);
    check_output("fetch_ren_cycles", W'(dut_ren - base_ren), W'(3));
    check_output("fetch_ihit_count", W'(dut_i_cnt - start_i), W'(1));

    // Simultaneous fetch and store: data wins first.
    i_r = 1'b1; d_w = 1'b1;
    start_i = dut_i_cnt; start_d = dut_d_cnt;
    for (int k = 0; k < 12 && (i_r || d_w); k++) begin
      apply_stimulus(0, i_r, 0, d_w, W'(32'h80), W'(32'h100), W'(32'hDEADBEEF),
                     W'(32'h12345678) ^ W'(k), ACCESS);
      if (i_r && dut_i_cnt != start_i) begin
        check_output("dgnt_before_ignt", W'(dut_d_cnt - start_d), W'(1));
        i_r = 1'b0;
      end
      if (dut_d_cnt != start_d) d_w = 1'b0;
    end
    check_output("simul_done", W'({i_r, d_w}), '0);
    apply_stimulus(0, 0, 0, 0, '0, '0, '0, '0, FREE);

    // Starvation: fetch and load both held, RAM always ready.
    start_i = dut_i_cnt; start_d = dut_d_cnt;
    for (int k = 0; k < 40 && dut_i_cnt == start_i; k++)
      apply_stimulus(0, 1, 1, 0, W'(32'h200), W'(32'h300), '0, W'($urandom), ACCESS);
    check_output("starve_ihit", W'(dut_i_cnt - start_i), W'(1));
    check_output("starve_dhits", W'(dut_d_cnt - start_d), W'(SMAX));
    apply_stimulus(0, 0, 0, 0, '0, '0, '0, '0, FREE);

    // RAM error on a load, then retry succeeds.
    start_m = dut_merr_cnt;
    apply_stimulus(0, 0, 1, 0, '0, W'(32'h44), '0, W'(32'h55), ERROR);
    apply_stimulus(0, 0, 1, 0, '0, W'(32'h44), '0, W'(32'h55), ERROR);
    check_output("err_merr", W'(merr), W'(1));
    check_output("err_no_dhit", W'(dhit), '0);
    apply_stimulus(0, 0, 1, 0, '0, W'(32'h44), '0, W'(32'h66), ACCESS);
    check_output("err_idle_ren", W'(ramREN), '0);
    apply_stimulus(0, 0, 1, 0, '0, W'(32'h44), '0, W'(32'h77), ACCESS);
    check_output("err_regrant_dhit", W'(dhit), W'(1));
    apply_stimulus(0, 0, 0, 0, '0, '0, '0, '0, FREE);
    check_output("err_merr_count", W'(dut_merr_cnt - start_m), W'(1));

    // Reset while fetch is granted and RAM busy.
    start_i = dut_i_cnt;
    apply_stimulus(0, 1, 0, 0, W'(32'h60), '0, '0, '0, BUSY);
    apply_stimulus(0, 1, 0, 0, W'(32'h60), '0, '0, '0, BUSY);
    check_output("rst_ignt_ren", W'(ramREN), W'(1));
    apply_stimulus(1, 1, 0, 0, W'(32'h60), '0, '0, W'(32'hAAAA5555), ACCESS);
    check_output("rst_no_ihit", W'(ihit), '0);
    apply_stimulus(0, 1, 0, 0, W'(32'h60), '0, '0, '0, BUSY);
    check_output("rst_idle_ren", W'(ramREN), '0);
    for (int k = 0; k < 6 && dut_i_cnt == start_i; k++)
      apply_stimulus(0, 1, 0, 0, W'(32'h60), '0, '0, W'(32'h0BADF00D), ACCESS);
    check_output("rst_fetch_after", W'(dut_i_cnt - start_i), W'(1));
    apply_stimulus(0, 0, 0, 0, '0, '0, '0, '0, FREE);

    // Load dropped mid-access.
    start_d = dut_d_cnt; start_m = dut_merr_cnt;
    apply_stimulus(0, 0, 1, 0, '0, W'(32'h88), '0, '0, BUSY);
    apply_stimulus(0, 0, 1, 0, '0, W'(32'h88), '0, '0, BUSY);
    apply_stimulus(0, 0, 0, 0, '0, W'(32'h88), '0, '0, BUSY);
    apply_stimulus(0, 0, 0, 0, '0, '0, '0, '0, ACCESS);
    check_output("drop_idle_ren", W'(ramREN), '0);
    check_output("drop_no_dhit", W'(dut_d_cnt - start_d), '0);
    check_output("drop_no_merr", W'(dut_merr_cnt - start_m), '0);

    for (int k = 0; k < 1500; k++) random_cycle();

    repeat (3) apply_stimulus(0, 0, 0, 0, '0, '0, '0, '0, FREE);
    check_output("queue_empty", W'(exp_q.size()), '0);
    check_output("ren_cycle_total", W'(dut_ren), W'(exp_ren));
    check_output("wen_cycle_total", W'(dut_wen), W'(exp_wen));
    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_W, default 32, data and address width in bits.
REQ-002 Parameter STARVE_MAX, default 3, consecutive data grants tolerated while an instruction fetch waits (legal range 1..15).
REQ-003 CLK  input  1  pipeline clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 iREN  input  1  instruction fetch request, held until ihit.
REQ-006 iaddr  input  WORD_W  instruction fetch address.
REQ-007 dREN  input  1  data load request, held until dhit.
REQ-008 dWEN  input  1  data store request, held until dhit; dREN and dWEN never both high.
REQ-009 daddr  input  WORD_W  data address.
REQ-010 dstore  input  WORD_W  store data.
REQ-011 ihit  output  1  one-cycle pulse: fetch complete, iload valid.
REQ-012 dhit  output  1  one-cycle pulse: data access complete, dload valid for loads.
REQ-013 iload  output  WORD_W  fetched instruction.
REQ-014 dload  output  WORD_W  loaded data.
REQ-015 merr  output  1  one-cycle pulse: RAM reported ERROR on the granted access.
REQ-016 ramREN, ramWEN  output  1 each  RAM read / write strobes.
REQ-017 ramaddr, ramstore  output  WORD_W each  RAM address and write data.
REQ-018 ramload  input  WORD_W  RAM read data.
REQ-019 ramstate  input  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-020 FSM states SHALL be IDLE, IGNT, DGNT; RAM strobes are low in IDLE.
REQ-021 In IDLE, a data request (dREN|dWEN) SHALL go to DGNT unless iREN is high and starve_cnt equals STARVE_MAX, in which case IGNT.
REQ-022 In IDLE, iREN alone SHALL go to IGNT; no request stays IDLE.
REQ-023 In IGNT: ramREN=1, ramWEN=0, ramaddr=iaddr; in DGNT: ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore; ramstore=0 otherwise.
REQ-024 In a granted state with ramstate==ACCESS, the matching hit SHALL be asserted combinationally that cycle, iload/dload SHALL equal ramload, and the FSM SHALL return to IDLE next edge.
REQ-025 With ramstate FREE or BUSY the FSM SHALL hold its grant state, strobes unchanged, no hit.
REQ-026 With ramstate==ERROR in a granted state, merr SHALL pulse, no hit SHALL assert, FSM returns to IDLE (requester retries by holding request).
REQ-027 If the granted requester drops its request mid-access, the FSM SHALL return to IDLE next edge without hit or merr.
REQ-028 Minimum latency: request seen in IDLE at edge N, grant state from edge N+1, earliest hit in cycle N+1.
REQ-029 Back-to-back: a new arbitration SHALL occur only from IDLE, so at most one completion per two cycles.
REQ-030 starve_cnt (4 bits) SHALL increment on each dhit while iREN is high, saturating at STARVE_MAX, and clear on ihit.
REQ-031 hit outputs and merr SHALL be 0 outside granted states; iload/dload SHALL be 0 when their hit is low.

Reset
REQ-032 RST high at an edge SHALL force IDLE and starve_cnt=0, overriding any access in progress; outputs then per REQ-020/031.
REQ-033 Reset asserted mid-grant SHALL produce no hit for the aborted access.

Verification
REQ-034 Fetch only: iREN=1, iaddr=0x40, ramstate ACCESS after 2 BUSY cycles, ramload=0x8C220004 -> ramREN high 3 cycles, ihit one cycle with iload=0x8C220004, then IDLE.
REQ-035 Simultaneous iREN and dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> DGNT first (ramWEN=1, ramaddr=0x100), dhit, then IGNT, ihit.
REQ-036 Starvation: STARVE_MAX=3, iREN held, dREN reasserted after every dhit, RAM always ACCESS -> exactly 3 dhit, then ihit, starve_cnt back to 0.
REQ-037 ERROR: dREN=1, ramstate=ERROR in DGNT -> merr one cycle, dhit never, FSM IDLE, regrant DGNT next cycle.
REQ-038 RST pulsed while in IGNT with ramstate BUSY -> next cycle IDLE, ramREN=0, no ihit; later fetch completes normally.
REQ-039 Request drop: dREN deasserted while DGNT with BUSY -> IDLE next edge, no dhit, no merr.
